mio_bus_arbiter: RTL and testbench
==================================

Name: mio_bus_arbiter

Overview:
- Shares the single CPU memory/IO port (MIO bus) between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Registers the winning request and drives the bus until the peripheral answers with MIO_ready, then returns read data and a one-cycle ack.
- Generates per-stage stall signals consumed by the pipeline hazard logic.
- Sits between the pipeline stages and the MIO bus fabric.

Parameters:
- ADDR_W, 32, address width of the IF/MEM/bus address.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum consecutive MEM grants while IF is waiting before IF is forced a grant (legal range 1..15).
- TIMEOUT_CYC, 255, BUSY cycles without MIO_ready before abort (used only with MIO_TIMEOUT_EN; legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request, held high until if_ack.
- if_addr  in  ADDR_W  IF fetch address.
- if_rdata  out  DATA_W  fetched word, valid when if_ack is high.
- if_ack  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM request, held high until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data, valid when mem_ack is high.
- mem_ack  out  1  one-cycle completion pulse for MEM.
- Addr_out  out  ADDR_W  bus address.
- Data_out  out  DATA_W  bus write data.
- mem_w  out  1  bus write strobe.
- Data_in  in  DATA_W  bus read data.
- MIO_ready  in  1  bus transaction complete.
- CPU_MIO  out  1  bus access in progress.
- stall_if  out  1  asserted when if_req is high and if_ack is low (combinational).
- stall_mem  out  1  asserted when mem_req is high and mem_ack is low (combinational).
- bus_err  out  1  one-cycle timeout pulse; tied 0 when the optional feature is absent.

Behaviour:
- Clocking: single clock domain clk; rst is synchronous and active-high.
- Reset: state IDLE, owner = none, starve_cnt = 0.
  - All registered outputs are 0: CPU_MIO, mem_w, Addr_out, Data_out, if_rdata, mem_rdata, if_ack, mem_ack, bus_err.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner:
    - MEM wins by default.
    - IF wins if mem_req is low, or if starve_cnt == STARVE_LIMIT and if_req is high.
  - On the grant, latch the winner's address, wdata and we (0 for IF) and the owner into registers, then go to BUSY.
- BUSY:
  - CPU_MIO = 1; Addr_out and Data_out come from the latched values; mem_w = latched we.
  - The bus is driven only from registers and never changes mid-transaction.
  - When MIO_ready is high: capture Data_in into the owner's rdata register (loads/fetches only; stores leave mem_rdata unchanged), then go to DONE.
- DONE:
  - The owner's ack is high for exactly this cycle. CPU_MIO, mem_w and Data_out return to 0.
  - No arbitration happens in DONE.
  - Next state is IDLE, which samples requests again. A requester may present its next request in its ack cycle; it is considered from the following IDLE.
- Latency:
  - Request visible in IDLE at cycle N; bus driven from N+1.
  - If MIO_ready is high at N+1, ack is high at N+2.
  - Minimum 3 cycles per transaction back-to-back.
- Starvation counter:
  - Increments on every MEM grant made while if_req is high.
  - Resets to 0 on any IF grant, or when a MEM grant occurs with if_req low.
  - Saturates at STARVE_LIMIT.
- Simultaneous events: MIO_ready arriving in IDLE or DONE is ignored. A request dropped while its transaction is in BUSY is still completed and acked; the ack is then spurious and the requester must ignore it.
- Reset mid-operation: the next state is IDLE, no ack is issued, and the bus is released in the cycle after rst is sampled.
- Widths: no arithmetic on data. Counters are 4 bits (starve) and 8 bits (timeout).

Optional Feature:
- Macro MIO_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle with MIO_ready low.
  - When the count reaches TIMEOUT_CYC, go to DONE. The owner is acked with rdata = 32'hDEADBEEF (stores: rdata unchanged), and bus_err pulses high in the DONE cycle.
- Undefined: BUSY waits indefinitely and bus_err is constant 0.

Test Plan:
- Single IF fetch: if_req=1 with if_addr=0x0000_0040; MIO_ready=1 on the first BUSY cycle with Data_in=0x2008_0005 -> CPU_MIO=1 and Addr_out=0x40 for 1 cycle; if_ack=1 and if_rdata=0x2008_0005 two cycles after the request; stall_if high until the ack.
- Store: mem_req=1, mem_we=1, mem_addr=0x0000_0100, mem_wdata=0x1234_5678; MIO_ready delayed 3 cycles -> mem_w=1 and Data_out=0x1234_5678 held for exactly 4 BUSY cycles; then mem_ack pulse, with mem_rdata unchanged.
- Contention and starvation: if_req and mem_req held continuously with STARVE_LIMIT=4 and MIO_ready always 1 -> grant order MEM,MEM,MEM,MEM,IF,MEM...
- Reset mid-BUSY: assert rst for 1 cycle during BUSY -> next cycle CPU_MIO=0, mem_w=0, no ack; a request still held after rst is re-granted from IDLE.
- Timeout (MIO_TIMEOUT_EN, TIMEOUT_CYC=8): mem load with MIO_ready=0 forever -> mem_ack and bus_err pulse together; mem_rdata=0xDEADBEEF; FSM back in IDLE the next cycle.

Source files
------------

// File: rtl/mio_bus_arbiter_if.sv
// Interface bundle for mio_bus_arbiter: the IF/MEM request ports, the MIO bus and the stall/debug outputs.
// The slave modport is the arbiter's view; master is the view of the pipeline plus the bus fabric.
interface mio_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with stable address/data and holds it until the
  // matching *_ack pulse, which is high for exactly one cycle. *_rdata is valid only in
  // that ack cycle. On the bus, CPU_MIO marks an access in progress with Addr_out,
  // Data_out and mem_w held stable; the fabric ends it by raising MIO_ready for one cycle.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [ADDR_W-1:0] Addr_out;
  logic [DATA_W-1:0] Data_out;
  logic              mem_w;
  logic [DATA_W-1:0] Data_in;
  logic              MIO_ready;
  logic              CPU_MIO;

  logic              stall_if;
  logic              stall_mem;
  logic              bus_err;
  logic [1:0]        fsm_state;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, Data_in, MIO_ready,
    output if_rdata, if_ack, mem_rdata, mem_ack, Addr_out, Data_out, mem_w, CPU_MIO,
           stall_if, stall_mem, bus_err, fsm_state
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, Data_in, MIO_ready,
    input  if_rdata, if_ack, mem_rdata, mem_ack, Addr_out, Data_out, mem_w, CPU_MIO,
           stall_if, stall_mem, bus_err, fsm_state
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
// MIO bus arbiter: shares one memory/IO port between the IF and MEM pipeline stages.
// Optional bus timeout (bus_err, 0xDEADBEEF read data) is compiled in with `define MIO_TIMEOUT_EN.
module mio_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic             clk,
  input  logic             rst,
  mio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;

  // The bus output registers double as the latched request for the whole BUSY phase.
  logic              cpu_mio_q, cpu_mio_d;
  logic              mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              if_wins;

`ifdef MIO_TIMEOUT_EN
  localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hDEADBEEF);
  logic [7:0] tmo_q, tmo_d;
  logic       bus_err_q, bus_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      cpu_mio_q   <= 1'b0;
      mem_w_q     <= 1'b0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
`ifdef MIO_TIMEOUT_EN
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      cpu_mio_q   <= cpu_mio_d;
      mem_w_q     <= mem_w_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
`ifdef MIO_TIMEOUT_EN
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    cpu_mio_d   = cpu_mio_q;
    mem_w_d     = mem_w_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    // IF only overtakes a pending MEM request once MEM has won STARVE_LIMIT times in a row.
    if_wins     = bus.if_req && (!bus.mem_req || (starve_q == STARVE_MAX));
`ifdef MIO_TIMEOUT_EN
    tmo_d       = tmo_q;
    bus_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          state_d   = BUSY;
          cpu_mio_d = 1'b1;
`ifdef MIO_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (if_wins) begin
            owner_d    = OWN_IF;
            addr_out_d = bus.if_addr;
            data_out_d = '0;
            mem_w_d    = 1'b0;
            starve_d   = '0;
          end else begin
            owner_d    = OWN_MEM;
            addr_out_d = bus.mem_addr;
            data_out_d = bus.mem_wdata;
            mem_w_d    = bus.mem_we;
            if (!bus.if_req)                starve_d = '0;
            else if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
          end
        end
      end

      BUSY: begin
        if (bus.MIO_ready) begin
          state_d    = DONE;
          cpu_mio_d  = 1'b0;
          mem_w_d    = 1'b0;
          addr_out_d = '0;
          data_out_d = '0;
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus.Data_in;
            if_ack_d   = 1'b1;
          end else begin
            if (!mem_w_q) mem_rdata_d = bus.Data_in;
            mem_ack_d = 1'b1;
          end
        end
`ifdef MIO_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d    = DONE;
          cpu_mio_d  = 1'b0;
          mem_w_d    = 1'b0;
          addr_out_d = '0;
          data_out_d = '0;
          bus_err_d  = 1'b1;
          if (owner_q == OWN_IF) begin
            if_rdata_d = ERR_WORD;
            if_ack_d   = 1'b1;
          end else begin
            if (!mem_w_q) mem_rdata_d = ERR_WORD;
            mem_ack_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign bus.CPU_MIO   = cpu_mio_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.Addr_out  = addr_out_q;
  assign bus.Data_out  = data_out_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.mem_req & ~mem_ack_q;
  assign bus.fsm_state = state_q;

`ifdef MIO_TIMEOUT_EN
  assign bus.bus_err = bus_err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Testbench for mio_bus_arbiter: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model of the arbitration rules.
module tb_mio_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mio_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_valid = 1'b0;
  bit          m_on_bus, m_ack, m_err, m_we;
  int          m_owner;    // 0 none, 1 IF, 2 MEM
  int          m_streak;   // MEM wins in a row while IF waited
  int          m_waited;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_mem_rdata;

  always @(negedge clk) begin
    if (m_valid) begin
      check("cpu_mio",   bus.CPU_MIO,   m_on_bus);
      check("mem_w",     bus.mem_w,     m_on_bus && m_we);
      if (m_on_bus) check("addr_out", bus.Addr_out, m_addr);
      check("data_out",  bus.Data_out,  m_on_bus ? m_wdata : '0);
      check("if_ack",    bus.if_ack,    m_ack && m_owner == 1);
      check("mem_ack",   bus.mem_ack,   m_ack && m_owner == 2);
      check("if_rdata",  bus.if_rdata,  m_if_rdata);
      check("mem_rdata", bus.mem_rdata, m_mem_rdata);
      check("bus_err",   bus.bus_err,   m_err);
      check("stall_if",  bus.stall_if,  bus.if_req && !(m_ack && m_owner == 1));
      check("stall_mem", bus.stall_mem, bus.mem_req && !(m_ack && m_owner == 2));
    end
    // advance to the values the DUT must show after the coming edge
    if (rst) begin
      m_valid = 1'b1; m_on_bus = 0; m_ack = 0; m_err = 0; m_we = 0;
      m_owner = 0; m_streak = 0; m_waited = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_mem_rdata = '0;
    end else if (m_valid) begin
      if (m_ack) begin
        m_ack = 0; m_err = 0; m_owner = 0;
      end else if (m_on_bus) begin
        if (bus.MIO_ready) begin
          if (m_owner == 1) m_if_rdata = bus.Data_in;
          else if (!m_we)   m_mem_rdata = bus.Data_in;
          m_on_bus = 0; m_ack = 1;
        end
`ifdef MIO_TIMEOUT_EN
        else begin
          m_waited++;
          if (m_waited == TC) begin
            if (m_owner == 1) m_if_rdata = 32'hDEADBEEF;
            else if (!m_we)   m_mem_rdata = 32'hDEADBEEF;
            m_on_bus = 0; m_ack = 1; m_err = 1;
          end
        end
`endif
      end else if (bus.if_req || bus.mem_req) begin
        if (bus.if_req && (!bus.mem_req || m_streak == SL)) begin
          m_owner = 1; m_addr = bus.if_addr; m_wdata = '0; m_we = 0; m_streak = 0;
        end else begin
          m_owner = 2; m_addr = bus.mem_addr; m_wdata = bus.mem_wdata; m_we = bus.mem_we;
          m_streak = bus.if_req ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
        end
        m_on_bus = 1; m_waited = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy;
    int grants;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.Data_in = '0; bus.MIO_ready = 0;
    repeat (2) tick();
    check("rst_cpu_mio", bus.CPU_MIO, 0);
    check("rst_if_ack",  bus.if_ack,  0);
    check("rst_mem_w",   bus.mem_w,   0);
    rst = 1'b0;

    // single IF fetch
    bus.if_addr = 32'h0000_0040; bus.Data_in = 32'h2008_0005; bus.MIO_ready = 1; bus.if_req = 1;
    #1 check("t1_stall_if_pre", bus.stall_if, 1);
    tick();
    check("t1_cpu_mio", bus.CPU_MIO, 1);
    check("t1_addr",    bus.Addr_out, 32'h40);
    check("t1_no_ack",  bus.if_ack, 0);
    check("t1_stall_if_busy", bus.stall_if, 1);
    tick();
    check("t1_ack",      bus.if_ack, 1);
    check("t1_rdata",    bus.if_rdata, 32'h2008_0005);
    check("t1_released", bus.CPU_MIO, 0);
    check("t1_stall_if_ack", bus.stall_if, 0);
    bus.if_req = 0; bus.MIO_ready = 0;
    tick();
    check("t1_ack_once", bus.if_ack, 0);

    // store with MIO_ready delayed 3 cycles
    bus.mem_we = 1; bus.mem_addr = 32'h0000_0100; bus.mem_wdata = 32'h1234_5678; bus.mem_req = 1;
    busy = 0;
    for (int i = 0; i < 20 && !bus.mem_ack; i++) begin
      tick();
      if (bus.CPU_MIO) begin
        busy++;
        check("t2_mem_w", bus.mem_w, 1);
        check("t2_data_out", bus.Data_out, 32'h1234_5678);
        if (busy == 4) bus.MIO_ready = 1;
      end
    end
    check("t2_busy_cycles", busy, 4);
    check("t2_ack", bus.mem_ack, 1);
    check("t2_rdata_kept", bus.mem_rdata, 32'h0);
    bus.mem_req = 0; bus.mem_we = 0; bus.MIO_ready = 0;
    tick();

    // contention: grant order MEM x4, IF, MEM
    exp_q = {32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'hA0, 32'hB0};
    bus.if_addr = 32'hA0; bus.mem_addr = 32'hB0; bus.if_req = 1; bus.mem_req = 1; bus.MIO_ready = 1;
    grants = 0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      tick();
      if (bus.CPU_MIO) begin
        check($sformatf("t3_grant%0d", grants), bus.Addr_out, exp_q.pop_front());
        grants++;
      end
    end
    check("t3_grant_count", grants, 6);
    bus.if_req = 0; bus.mem_req = 0;
    repeat (4) tick();
    bus.MIO_ready = 0;

    // reset in the middle of BUSY
    bus.mem_addr = 32'h200; bus.mem_req = 1;
    tick();
    check("t4_busy", bus.CPU_MIO, 1);
    tick();
    rst = 1;
    tick();
    check("t4_cpu_mio_off", bus.CPU_MIO, 0);
    check("t4_mem_w_off",   bus.mem_w, 0);
    check("t4_no_ack",      bus.mem_ack, 0);
    rst = 0;
    tick();
    check("t4_regrant",      bus.CPU_MIO, 1);
    check("t4_regrant_addr", bus.Addr_out, 32'h200);
    bus.MIO_ready = 1; bus.Data_in = 32'hCAFE_F00D;
    tick();
    check("t4_ack",   bus.mem_ack, 1);
    check("t4_rdata", bus.mem_rdata, 32'hCAFE_F00D);
    bus.mem_req = 0; bus.MIO_ready = 0;
    tick();

`ifdef MIO_TIMEOUT_EN
    // timeout: load with MIO_ready low forever
    bus.mem_we = 0; bus.mem_addr = 32'h300; bus.mem_req = 1;
    busy = 0;
    for (int i = 0; i < 30 && !bus.mem_ack; i++) begin
      tick();
      if (bus.CPU_MIO) busy++;
    end
    check("t5_busy_cycles", busy, TC);
    check("t5_ack",   bus.mem_ack, 1);
    check("t5_err",   bus.bus_err, 1);
    check("t5_rdata", bus.mem_rdata, 32'hDEADBEEF);
    bus.mem_req = 0;
    tick();
    check("t5_err_once", bus.bus_err, 0);
    check("t5_idle",     bus.CPU_MIO, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      bus.MIO_ready = ($urandom_range(0, 2) == 0);
      bus.Data_in = $urandom;
      if (bus.if_req && bus.if_ack) begin
        bus.if_req = $urandom_range(0, 1);
        bus.if_addr = $urandom;
      end else if (bus.if_req && $urandom_range(0, 59) == 0) begin
        bus.if_req = 0;
      end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1;
        bus.if_addr = $urandom;
      end
      if (bus.mem_req && bus.mem_ack) begin
        bus.mem_req = $urandom_range(0, 1);
        bus.mem_we = $urandom_range(0, 1);
        bus.mem_addr = $urandom;
        bus.mem_wdata = $urandom;
      end else if (bus.mem_req && $urandom_range(0, 59) == 0) begin
        bus.mem_req = 0;
      end else if (!bus.mem_req && $urandom_range(0, 1) == 0) begin
        bus.mem_req = 1;
        bus.mem_we = $urandom_range(0, 1);
        bus.mem_addr = $urandom;
        bus.mem_wdata = $urandom;
      end
    end

    rst = 0; bus.if_req = 0; bus.mem_req = 0; bus.MIO_ready = 1;
    repeat (6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
